// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg: shared FSM encoding and requester port indices
package axi_read_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_AR, ARB_RDATA} arb_state_e;
  localparam logic ARB_ICACHE = 1'b0;
  localparam logic ARB_DCACHE = 1'b1;
endpackage

// File: rtl/axi_read_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, the port not granted last wins a tie
module rr_arb2
  import axi_read_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx   = &req ? ~last_grant : (req[1] ? ARB_DCACHE : ARB_ICACHE);
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one memory AXI read channel between icache and dcache
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  output logic                  busy,
  output logic                  proto_err
);
  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d, cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic                  gnt_valid, gnt_idx, grant, ar_hs, beat, rd;

  rr_arb2 u_rr (
    .req        ({s1_arvalid, s0_arvalid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign grant = state_q == ARB_IDLE && gnt_valid;
  assign ar_hs = state_q == ARB_AR && m_axi_arready;
  assign rd    = state_q == ARB_RDATA;
  assign beat  = m_axi_rvalid && m_axi_rready;

  // next-state: latch the winner on grant, count beats, flag ID and length mismatches
  always_comb begin
    state_d      = grant ? ARB_AR : ar_hs ? ARB_RDATA : (beat && m_axi_rlast) ? ARB_IDLE : state_q;
    last_grant_d = grant ? gnt_idx : last_grant_q;
    addr_d       = grant ? (gnt_idx ? s1_araddr : s0_araddr) : addr_q;
    len_d        = grant ? (gnt_idx ? s1_arlen : s0_arlen) : len_q;
    size_d       = grant ? (gnt_idx ? s1_arsize : s0_arsize) : size_q;
    burst_d      = grant ? (gnt_idx ? s1_arburst : s0_arburst) : burst_q;
    cnt_d        = grant ? 8'd0 : beat ? cnt_q + 8'd1 : cnt_q;
    err_d        = err_q | (beat && (m_axi_rid != m_axi_arid || m_axi_rlast != (cnt_q == len_q)));
  end

  // state registers; reset abandons any in-flight burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ARB_ICACHE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign s0_arready    = !reset && grant && gnt_idx == ARB_ICACHE;
  assign s1_arready    = !reset && grant && gnt_idx == ARB_DCACHE;
  assign m_axi_arvalid = state_q == ARB_AR;
  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, last_grant_q};
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_rready  = rd && (last_grant_q ? s1_rready : s0_rready);
  assign s0_rvalid     = rd && last_grant_q == ARB_ICACHE && m_axi_rvalid;
  assign s1_rvalid     = rd && last_grant_q == ARB_DCACHE && m_axi_rvalid;
  assign s0_rdata      = m_axi_rdata;
  assign s1_rdata      = m_axi_rdata;
  assign s0_rresp      = m_axi_rresp;
  assign s1_rresp      = m_axi_rresp;
  assign s0_rlast      = m_axi_rlast;
  assign s1_rlast      = m_axi_rlast;
  assign busy          = state_q != ARB_IDLE;
  assign proto_err     = err_q;
endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the single memory-side AXI read address/data channel pair between the instruction cache (port 0) and the data cache (port 1). It sits between both caches and the top-level memory AXI master, and handles one outstanding read burst at a time with round-robin arbitration. It also performs ID tagging and burst-length checking. Write channels (AW/W/B) and snoop channels (AC) are owned by the data cache directly and are not routed through this block.

## Interface
- ID_WIDTH, 13, AXI ID width
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI data width
- clk  in  1  single clock; all state rising-edge
- reset  in  1  asynchronous, active-high
- s{0,1}_arvalid / s{0,1}_arready  in / out  1 each  requester AR handshake (0 = icache, 1 = dcache)
- s{0,1}_araddr  in  ADDR_WIDTH  requester address
- s{0,1}_arlen / _arsize / _arburst  in  8 / 3 / 2  requester burst descriptor
- s{0,1}_rvalid / s{0,1}_rready  out / in  1 each  requester R handshake
- s{0,1}_rdata / _rresp / _rlast  out  DATA_WIDTH / 2 / 1  requester read data (shared bus, qualified by rvalid)
- m_axi_arvalid / m_axi_arready  out / in  1  memory AR handshake
- m_axi_arid / _araddr / _arlen / _arsize / _arburst  out  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  memory AR fields
- m_axi_arlock / _arcache / _arprot  out  1 / 4 / 3  constant 0
- m_axi_rvalid / m_axi_rready  in / out  1  memory R handshake
- m_axi_rid / _rdata / _rresp / _rlast  in  ID_WIDTH / DATA_WIDTH / 2 / 1  memory read data
- busy  out  1  a burst is in flight (state != IDLE)
- proto_err  out  1  sticky; set on ID or burst-length mismatch; cleared only by reset

## Operation
- FSM states and transitions:
  - IDLE -> AR on any s_arvalid (grant issued)
  - AR -> RDATA on m_axi_arvalid && m_axi_arready
  - RDATA -> IDLE on the final beat: m_axi_rvalid && m_axi_rready && m_axi_rlast
- Arbitration happens only in IDLE.
  - Single requester: it wins.
  - Both requesting: the port not granted last wins.
  - last_grant resets to 0, so the first tie after reset goes to dcache (port 1).
- Grant cycle: s{g}_arready = 1 for exactly that cycle; the loser's arready stays 0. The winner's addr/len/size/burst are latched into registers, and grant index g is latched.
- AR state:
  - m_axi_arvalid = 1, with latched fields and m_axi_arid = g zero-extended to ID_WIDTH.
  - Fields are held stable until m_axi_arready.
- RDATA state:
  - Granted port: s{g}_rvalid = m_axi_rvalid. Non-granted port: s_rvalid = 0.
  - m_axi_rready = s{g}_rready.
  - rdata, rresp and rlast are forwarded unmodified to both ports.
  - An 8-bit beat counter starts at 0 and increments on each accepted beat.
- Error checks, each on an accepted beat; all set proto_err:
  - m_axi_rid != g
  - rlast while count != latched arlen
  - count == arlen without rlast
- Errors never change forwarding or the FSM; rlast alone ends the burst.
- m_axi_rready = 0 outside RDATA; s_arready = 0 outside IDLE and while reset is high.

## Timing
- Reset values: state IDLE, last_grant 0, beat count 0, busy 0, proto_err 0, m_axi_arvalid 0, all m_axi_ar* fields 0, m_axi_rready 0, s_arready 0, s_rvalid 0.
- s_arready is combinational from state/arvalid/last_grant, and is asserted in the same cycle as arvalid when IDLE.
- m_axi_arvalid rises the cycle after the grant: minimum 1-cycle added AR latency.
- R path is purely combinational: 0-cycle added latency.
- Back-to-back bursts: the final beat in cycle N returns to IDLE at N+1; a new grant is possible in cycle N+1.
- A new arvalid arriving while busy waits with arready 0. Requesters hold arvalid per AXI.
- Reset asserted mid-burst: immediate return to IDLE, the in-flight burst is abandoned, and outputs take reset values. Draining the memory side is the system's responsibility.
- A requester dropping arvalid before its grant is legal and causes no grant.

## Structure
- Shared package: FSM enum (ARB_IDLE, ARB_AR, ARB_RDATA) and port constants ARB_ICACHE = 0, ARB_DCACHE = 1.
- One sub-module: rr_arb2, a two-way round-robin picker (req[1:0], last_grant -> gnt_valid, gnt_idx). last_grant is stored in axi_read_arbiter.
- Latch registers, beat counter, checks and routing live in axi_read_arbiter.

## Test plan
- **Single icache read:** s0 araddr 0x1000, arlen 7 -> s0_arready one cycle; m_axi_arvalid next cycle with araddr 0x1000, arid 0, arlen 7; 8 beats delivered to s0 only; busy drops after the rlast beat; proto_err stays 0.
- **Simultaneous request after reset:** s0 and s1 assert arvalid in the same cycle -> s1 granted first (arid 1). When s1's rlast completes, s0 is granted the next cycle (arid 0).
- **Backpressure:**
  - m_axi_arready held 0 for 5 cycles -> arvalid and fields stay stable.
  - s1_rready toggling 1/0 during a 4-beat burst -> m_axi_rready mirrors it; no beat is lost or duplicated.
- **Protocol errors:**
  - rlast on beat 3 of an arlen 7 burst -> proto_err = 1 and stays set; state returns to IDLE.
  - Separately, rid = 5 on a port-0 burst -> proto_err = 1.
- **Reset mid-burst:** reset asserted after beat 2 of 8 -> state IDLE within the same cycle; m_axi_rready, busy and s_rvalid = 0. After reset is released, a new s0 request is granted normally.
